// File: rtl/if_fetch_stage.sv
// if_fetch_stage: PC, instruction-memory handshake, skid buffer and IF/ID register
module if_fetch_stage #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        clk,
  input  logic        reset_n,
  output logic        i_readM,
  output logic [15:0] i_address,
  input  logic [15:0] i_data,
  input  logic        i_ready,
  input  logic        stall,
  input  logic        redirect,
  input  logic [15:0] redirect_pc,
  input  logic        halt,
  output logic        ifid_valid,
  output logic [15:0] ifid_inst,
  output logic [15:0] ifid_pc_plus1,
  output logic [3:0]  opcode,
  output logic [1:0]  rs,
  output logic [1:0]  rt,
  output logic [1:0]  rd,
  output logic [5:0]  func_code,
  output logic [7:0]  imm,
  output logic [11:0] target,
  output logic [15:0] fetch_count
);
  typedef enum logic [2:0] {IDLE, FETCH, HOLD, DROP, HALTED} state_t;
  state_t state_q, state_d;
  logic [15:0] pc_q, pc_d, stale_q, stale_d, buf_q, buf_d;
  logic [15:0] inst_q, inst_d, pc1_q, pc1_d, cnt_q, cnt_d;
  logic valid_q, valid_d;
  assign i_readM = state_q == FETCH || state_q == DROP;
  assign i_address = state_q == DROP ? stale_q : pc_q;
  assign ifid_valid = valid_q;
  assign ifid_inst = inst_q;
  assign ifid_pc_plus1 = pc1_q;
  assign fetch_count = cnt_q;
  assign opcode = inst_q[15:12];
  assign rs = inst_q[11:10];
  assign rt = inst_q[9:8];
  assign rd = inst_q[7:6];
  assign func_code = inst_q[5:0];
  assign imm = inst_q[7:0];
  assign target = inst_q[11:0];
  // next state: halt beats redirect beats stall beats normal flow
  always_comb begin
    state_d = state_q;
    pc_d = pc_q;
    stale_d = stale_q;
    buf_d = buf_q;
    valid_d = valid_q;
    inst_d = inst_q;
    pc1_d = pc1_q;
    cnt_d = cnt_q;
    if (state_q == HALTED) begin
      state_d = HALTED;
    end else if (halt) begin
      state_d = HALTED;
      valid_d = 1'b0;
      inst_d = '0;
    end else if (redirect) begin
      pc_d = redirect_pc;
      valid_d = 1'b0;
      inst_d = '0;
      state_d = (state_q == FETCH || state_q == DROP) && !i_ready ? DROP : FETCH;
      if (state_q == FETCH) stale_d = pc_q;
    end else begin
      case (state_q)
        IDLE: state_d = FETCH;
        FETCH: begin
          if (i_ready) begin
            pc_d = pc_q + 16'd1;
            if (stall) begin
              buf_d = i_data;
              state_d = HOLD;
            end else begin
              valid_d = 1'b1;
              inst_d = i_data;
              pc1_d = pc_q + 16'd1;
              cnt_d = cnt_q + 16'd1;
            end
          end else if (!stall) begin
            valid_d = 1'b0;
            inst_d = '0;
          end
        end
        HOLD: begin
          if (!stall) begin
            valid_d = 1'b1;
            inst_d = buf_q;
            pc1_d = pc_q;
            cnt_d = cnt_q + 16'd1;
            state_d = FETCH;
          end
        end
        DROP: begin
          if (i_ready) state_d = FETCH;
          if (!stall) begin
            valid_d = 1'b0;
            inst_d = '0;
          end
        end
        default: state_d = state_q;
      endcase
    end
  end
  // state and pipeline register update
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      pc_q <= RESET_PC;
      stale_q <= '0;
      buf_q <= '0;
      valid_q <= 1'b0;
      inst_q <= '0;
      pc1_q <= '0;
      cnt_q <= '0;
    end else begin
      state_q <= state_d;
      pc_q <= pc_d;
      stale_q <= stale_d;
      buf_q <= buf_d;
      valid_q <= valid_d;
      inst_q <= inst_d;
      pc1_q <= pc1_d;
      cnt_q <= cnt_d;
    end
  end
endmodule

// File: tb/tb_if_fetch_stage.sv
// tb_if_fetch_stage: directed and randomized checks of the fetch stage against a program-order model
module tb_if_fetch_stage;
  logic clk = 0, reset_n = 0;
  logic i_readM, i_ready = 0, stall = 0, redirect = 0, halt = 0, ifid_valid;
  logic [15:0] i_address, i_data = 0, redirect_pc = 0, ifid_inst, ifid_pc_plus1, fetch_count;
  logic [3:0] opcode;
  logic [1:0] rs, rt, rd;
  logic [5:0] func_code;
  logic [7:0] imm;
  logic [11:0] target;
  int errors = 0, checks = 0;
  int wcnt = 0, need = 0, W = 0, deliveries = 0;
  bit busy = 0, rnd = 0, ovr_en = 0;
  logic [15:0] ovr_addr = 0, ovr_data = 0, exp_next, w;
  logic p_readM, p_ready, p_stall, p_redir, p_valid;
  logic [15:0] p_addr, p_rpc, p_fc, p_inst, p_pc1;
  if_fetch_stage dut (
    .clk(clk), .reset_n(reset_n), .i_readM(i_readM), .i_address(i_address),
    .i_data(i_data), .i_ready(i_ready), .stall(stall), .redirect(redirect),
    .redirect_pc(redirect_pc), .halt(halt), .ifid_valid(ifid_valid),
    .ifid_inst(ifid_inst), .ifid_pc_plus1(ifid_pc_plus1), .opcode(opcode),
    .rs(rs), .rt(rt), .rd(rd), .func_code(func_code), .imm(imm),
    .target(target), .fetch_count(fetch_count)
  );
  always #5 clk = ~clk;
  function automatic logic [15:0] memf(input logic [15:0] a);
    return (ovr_en && a == ovr_addr) ? ovr_data : 16'h4000 + a;
  endfunction
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, expv);
    end
  endtask
  task automatic cycle();
    if (i_readM) begin
      if (!busy) begin
        busy = 1;
        wcnt = 0;
        need = rnd ? int'($urandom_range(0, 3)) : W;
      end
      if (wcnt >= need) begin
        i_ready = 1;
        i_data = memf(i_address);
        busy = 0;
      end else begin
        i_ready = 0;
        i_data = 16'($urandom);
        wcnt++;
      end
    end else begin
      i_ready = 0;
      busy = 0;
    end
    p_readM = i_readM; p_ready = i_ready; p_addr = i_address;
    p_stall = stall; p_redir = redirect; p_rpc = redirect_pc;
    p_fc = fetch_count; p_valid = ifid_valid; p_inst = ifid_inst; p_pc1 = ifid_pc_plus1;
    @(posedge clk);
    @(negedge clk);
  endtask
  initial begin
    repeat (2) @(negedge clk);
    chk("rst_readM", i_readM, 0);
    chk("rst_valid", ifid_valid, 0);
    chk("rst_inst", ifid_inst, 0);
    chk("rst_pc1", ifid_pc_plus1, 0);
    chk("rst_count", fetch_count, 0);
    reset_n = 1;
    chk("idle_readM", i_readM, 0);
    cycle();
    chk("first_req", {i_readM, i_address}, {1'b1, 16'h0000});
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("zw_inst", ifid_inst, 32'h4000 + i);
      chk("zw_pc1", ifid_pc_plus1, i + 1);
      chk("zw_valid", ifid_valid, 1);
    end
    chk("zw_count", fetch_count, 3);
    W = 2;
    for (int k = 0; k < 2; k++) begin
      for (int j = 0; j < 2; j++) begin
        cycle();
        chk("ws_bubble", ifid_valid, 0);
        chk("ws_addr", i_address, 3 + k);
      end
      cycle();
      chk("ws_inst", ifid_inst, 32'h4003 + k);
      chk("ws_valid", ifid_valid, 1);
    end
    chk("ws_count", fetch_count, 5);
    cycle();
    chk("rd_pending", {i_readM, i_address, ifid_valid}, {1'b1, 16'h0005, 1'b0});
    redirect = 1; redirect_pc = 16'h0040;
    cycle();
    redirect = 0;
    chk("rd_drop", {i_readM, i_address, ifid_valid}, {1'b1, 16'h0005, 1'b0});
    cycle();
    chk("rd_newaddr", {i_readM, i_address, ifid_valid}, {1'b1, 16'h0040, 1'b0});
    chk("rd_count", fetch_count, 5);
    for (int j = 0; j < 2; j++) begin
      cycle();
      chk("rd_bubble", ifid_valid, 0);
    end
    cycle();
    chk("rd_inst", {ifid_valid, ifid_inst, ifid_pc_plus1}, {1'b1, 16'h4040, 16'h0041});
    W = 0;
    ovr_en = 1; ovr_addr = 16'h0041; ovr_data = 16'h6123;
    stall = 1;
    for (int j = 0; j < 3; j++) begin
      cycle();
      chk("st_hold", {ifid_valid, ifid_inst}, {1'b1, 16'h4040});
      chk("st_noreq", i_readM, 0);
      chk("st_count", fetch_count, 6);
    end
    stall = 0;
    cycle();
    w = 16'h6123;
    chk("st_release", {ifid_valid, ifid_inst, ifid_pc_plus1}, {1'b1, 16'h6123, 16'h0042});
    chk("st_count2", fetch_count, 7);
    chk("st_fields", {opcode, rs, rt, rd, func_code, imm}, {w[15:12], w[11:10], w[9:8], w[7:6], w[5:0], w[7:0]});
    chk("st_target", target, w[11:0]);
    chk("st_nextreq", {i_readM, i_address}, {1'b1, 16'h0042});
    cycle();
    chk("st_nodup", {ifid_inst, fetch_count}, {16'h4042, 16'd8});
    ovr_en = 0;
    halt = 1; redirect = 1; redirect_pc = 16'h0100;
    cycle();
    halt = 0; redirect = 0;
    for (int j = 0; j < 3; j++) begin
      chk("hl_state", {i_readM, ifid_valid, ifid_inst}, {1'b0, 1'b0, 16'h0000});
      chk("hl_pc", i_address, 16'h0043);
      chk("hl_count", fetch_count, 8);
      cycle();
    end
    reset_n = 0;
    #1;
    chk("hl_reset", {i_readM, i_address, fetch_count}, {1'b0, 16'h0000, 16'h0000});
    @(negedge clk);
    reset_n = 1;
    cycle();
    redirect = 1; redirect_pc = 16'hFFFF;
    cycle();
    redirect = 0;
    chk("wr_addr", {i_readM, i_address, ifid_valid}, {1'b1, 16'hFFFF, 1'b0});
    cycle();
    chk("wr_inst", {ifid_inst, ifid_pc_plus1, fetch_count}, {16'h3FFF, 16'h0000, 16'h0001});
    chk("wr_nextaddr", i_address, 16'h0000);
    repeat (65534) cycle();
    chk("wr_count_max", fetch_count, 16'hFFFF);
    cycle();
    chk("wr_count_wrap", {ifid_valid, fetch_count}, {1'b1, 16'h0000});
    reset_n = 0;
    @(negedge clk);
    reset_n = 1;
    cycle();
    rnd = 1;
    exp_next = 16'h0000;
    for (int n = 0; n < 2000; n++) begin
      stall = $urandom_range(0, 9) < 3;
      redirect = $urandom_range(0, 19) == 0;
      redirect_pc = 16'($urandom);
      cycle();
      if (p_readM && !p_ready) chk("rn_handshake", {i_readM, i_address}, {1'b1, p_addr});
      if (p_redir) begin
        chk("rn_flush", {ifid_valid, fetch_count}, {1'b0, p_fc});
        exp_next = p_rpc;
      end else if (p_stall) begin
        chk("rn_stall_reg", {ifid_valid, ifid_inst}, {p_valid, p_inst});
        chk("rn_stall_pc1", {ifid_pc_plus1, fetch_count}, {p_pc1, p_fc});
      end else if (fetch_count != p_fc) begin
        deliveries++;
        chk("rn_count", fetch_count, 16'(p_fc + 16'd1));
        chk("rn_order", 16'(ifid_pc_plus1 - 16'd1), exp_next);
        chk("rn_data", {ifid_valid, ifid_inst}, {1'b1, memf(16'(ifid_pc_plus1 - 16'd1))});
        exp_next = ifid_pc_plus1;
      end else begin
        chk("rn_bubble", {ifid_valid, ifid_inst}, {1'b0, 16'h0000});
      end
    end
    stall = 0; redirect = 0;
    chk("rn_liveness", deliveries > 100, 1);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
